dm_arbiter: RTL
===============

# dm_arbiter

Two-requester access controller for the 3072-word data memory. It sits between the CPU data port (requester 0) and the debug/loader port (requester 1) on one side and the single-port `dm` on the other. It grants the memory round-robin and sequences every access through a small FSM. Sub-word stores become read-modify-write sequences, because `dm` only supports full-word writes.

## Interface
Parameters:
- `DM_WORDS`, default 3072: number of implemented words; word index ≥ `DM_WORDS` is out of range.
- `AW`, default 12: `dm` word-address width.

Ports:
- `CLK` in 1: clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `m0_req`, `m1_req` in 1 each: request valid; held with fields stable until the matching done.
- `m0_we`, `m1_we` in 1 each: 1 = store, 0 = load.
- `m0_addr`, `m1_addr` in 32 each: byte address; word index = addr[13:2], other bits ignored.
- `m0_be`, `m1_be` in 4 each: byte enables for stores; ignored for loads.
- `m0_wdata`, `m1_wdata` in 32 each: store data, byte lanes already positioned.
- `m0_pc`, `m1_pc` in 32 each: PC of the issuing instruction, forwarded for write logging.
- `m0_done`, `m1_done` out 1 each: one-cycle completion pulse.
- `rdata` out 32: load data, valid while either done is high.
- `err` out 1: high with done when the access was out of range.
- `dm_addr` out AW: `dm` word address.
- `dm_wd` out 32: `dm` write data.
- `dm_we` out 1: `dm` write enable.
- `dm_pc` out 32: PC driven to `dm`.
- `dm_rd` in 32: `dm` combinational read data.

## Operation
- FSM states: IDLE, ACCESS, MERGE_WR, DONE.
- **IDLE**
  - If any request is present, select the winner: the lone requester, or on a tie the requester not in `last_gnt`.
  - Latch `id`, `we`, word index, `be`, `wdata` and `pc`; set `last_gnt <= id`; go to ACCESS.
- **ACCESS** (`dm_addr` = latched index)
  - Out of range: no write; `rdata_q <= 0`; `err_q <= 1`; go to DONE.
  - Load: `rdata_q <= dm_rd`; go to DONE.
  - Store with `be == 4'hF`: `dm_we = 1`, `dm_wd` = latched wdata; go to DONE.
  - Store with `be == 0`: no write; go to DONE.
  - Other store: `wd_q <= merge(dm_rd, wdata, be)`, where lane i takes wdata if be[i], else dm_rd; go to MERGE_WR.
- **MERGE_WR**: `dm_we = 1`, `dm_wd = wd_q`; go to DONE.
- **DONE**: `mX_done = 1` for the latched id only; `rdata = rdata_q`; `err = err_q`; clear `err_q`; go to IDLE unconditionally.
- `dm_pc` = latched pc in every non-IDLE state, else 0.
- `dm_addr` = latched index in non-IDLE states, else 0.
- `dm_we` is never high outside the two write cases above.

## Timing
- Reset values:
  - `state` IDLE, `last_gnt` 1 (so requester 0 wins the first tie).
  - `rdata_q`, `wd_q`, `err_q` all 0.
  - Outputs: all done 0, `err` 0, `rdata` 0, `dm_we` 0, `dm_addr` 0, `dm_wd` 0, `dm_pc` 0.
- Request sampled at edge E (in IDLE).
  - Load, full-word store, `be == 0` store, or out-of-range access: done high in cycle E+2.
  - Partial store: done high in cycle E+3.
- Minimum spacing between grants is 3 cycles (4 for partial stores). The IDLE cycle after DONE is a deliberate bubble: a requester drops `req` at the edge that ends DONE, so the same request is never re-accepted.
- A write happens exactly once per store, in a single cycle, at the rising edge ending ACCESS or MERGE_WR.
- A losing requester keeps `req` high and waits. It is never starved: with both requesting continuously, grants alternate.
- Reset asserted in any state: next state IDLE; no `dm_we` in that cycle or after; the pending done is dropped. `dm` is cleared by the same `Reset`.
- Fields changing while a request is granted do not affect the latched access.

## Structure
- Package `dm_arbiter_pkg` holds:
  - the state enum (IDLE/ACCESS/MERGE_WR/DONE, 2-bit);
  - `DM_WORDS = 3072`, `BE_FULL = 4'hF`, `BE_NONE = 4'h0`;
  - requester id constants `REQ_CPU = 0`, `REQ_DBG = 1`.
- One sub-module, `dm_byte_merge`: combinational 4-lane byte merge, ports old[31:0], new[31:0], be[3:0], out[31:0].
- Expected RTL size: 150–250 lines.

## Test plan
- **Load after reset:** after Reset, m0 loads 0x00000010 → `m0_done` at E+2, `rdata` 0, `err` 0, `dm_we` never high.
- **Full-word store:** m0 stores 0x12345678 to 0x00000008 with be F → `dm_we` high for one cycle with `dm_addr` 2 and `dm_pc` = m0_pc. A following m1 load of 0x00000008 returns 0x12345678 on `m1_done`.
- **Partial store:** next, m0 stores 0x00AB0000 to 0x00000008 with be 4'b0100 → word becomes 0x12AB5678, `dm_we` high exactly once, `m0_done` at E+3.
- **Arbitration:** after Reset, m0 and m1 request together and hold → grants go m0, m1, m0, m1. `m1_done` is never high for an m0 access and vice versa.
- **Out of range:** m1 stores to 0x00003000 (word 3072) → no `dm_we`, `m1_done` and `err` high together at E+2; a load of the same address returns 0 with `err` 1.
- **Reset mid-access:** Reset asserted while in MERGE_WR → `dm_we` 0 in that cycle, no done pulse, FSM in IDLE the next cycle, and the memory word unchanged apart from `dm` being cleared.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
`timescale 1ns/1ps
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int         DM_WORDS = 3072;
    localparam logic [3:0] BE_FULL  = 4'hF;
    localparam logic [3:0] BE_NONE  = 4'h0;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dm_arbiter_byte_merge.sv
// Combinational 4-lane byte merge: each lane takes new data when its enable is set.
`timescale 1ns/1ps
module dm_byte_merge (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] out_data
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign out_data[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin two-requester controller for the single-port data memory;
// sub-word stores are sequenced as read-modify-write.
`timescale 1ns/1ps
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DM_WORDS = dm_arbiter_pkg::DM_WORDS,
    parameter int AW       = 12
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [3:0]    m0_be,
    input  logic [31:0]   m0_wdata,
    input  logic [31:0]   m0_pc,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [3:0]    m1_be,
    input  logic [31:0]   m1_wdata,
    input  logic [31:0]   m1_pc,
    output logic          m0_done,
    output logic          m1_done,
    output logic [31:0]   rdata,
    output logic          err,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wd,
    output logic          dm_we,
    output logic [31:0]   dm_pc,
    input  logic [31:0]   dm_rd
);

    state_t      state;
    logic        last_gnt;
    logic        id_q;
    logic        we_q;
    logic [11:0] idx_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] rdata_q;
    logic [31:0] wd_q;
    logic        err_q;

    logic        grant_id;
    logic        in_range;
    logic [31:0] merged;

    // On a tie the requester that did not win last time gets the memory.
    assign grant_id = (m0_req && m1_req) ? ~last_gnt : m1_req;
    assign in_range = 32'(idx_q) < 32'(DM_WORDS);

    dm_byte_merge u_merge (
        .old_data (dm_rd),
        .new_data (wdata_q),
        .be       (be_q),
        .out_data (merged)
    );

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state    <= IDLE;
            last_gnt <= REQ_DBG;
            id_q     <= REQ_CPU;
            we_q     <= 1'b0;
            idx_q    <= '0;
            be_q     <= BE_NONE;
            wdata_q  <= '0;
            pc_q     <= '0;
            rdata_q  <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        id_q     <= grant_id;
                        last_gnt <= grant_id;
                        we_q     <= grant_id ? m1_we    : m0_we;
                        idx_q    <= grant_id ? m1_addr[13:2] : m0_addr[13:2];
                        be_q     <= grant_id ? m1_be    : m0_be;
                        wdata_q  <= grant_id ? m1_wdata : m0_wdata;
                        pc_q     <= grant_id ? m1_pc    : m0_pc;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!in_range) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else if (!we_q) begin
                        rdata_q <= dm_rd;
                        state   <= DONE;
                    end else if (be_q == BE_FULL || be_q == BE_NONE) begin
                        state   <= DONE;
                    end else begin
                        wd_q    <= merged;
                        state   <= MERGE_WR;
                    end
                end
                MERGE_WR: state <= DONE;
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        m0_done = 1'b0;
        m1_done = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        dm_addr = '0;
        dm_wd   = '0;
        dm_we   = 1'b0;
        dm_pc   = '0;
        if (state != IDLE) begin
            dm_addr = AW'(idx_q);
            dm_pc   = pc_q;
        end
        // Reset suppresses the write strobe and any pending completion in the same cycle.
        case (state)
            ACCESS: begin
                if (in_range && we_q && be_q == BE_FULL) begin
                    dm_we = !Reset;
                    dm_wd = wdata_q;
                end
            end
            MERGE_WR: begin
                dm_we = !Reset;
                dm_wd = wd_q;
            end
            DONE: begin
                m0_done = !Reset && (id_q == REQ_CPU);
                m1_done = !Reset && (id_q == REQ_DBG);
                rdata   = rdata_q;
                err     = !Reset && err_q;
            end
            default: ;
        endcase
    end

endmodule
